// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding Wishbone pipelined reads into a one-entry buffer.
// Optional FETCH_MISALIGN_CHECK_EN adds misaligned_o and traps misaligned redirect targets.
module fetch_unit #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h00000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        output_valid_o,
    input  logic        output_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        misaligned_o,
`endif
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i
);

    typedef enum logic [1:0] {
        START,
        REQUEST,
        WAIT_ACK,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] bpc_q, bpc_d;
    logic        valid_q, valid_d;
    logic        drop_q, drop_d;
    logic        mis_q, mis_d;
    logic [31:0] target;
    logic        transfer;
    logic        room;

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [31:0] NOP = 32'h00000013;
    logic target_mis;

    assign target     = branch_target_i;
    assign target_mis = |branch_target_i[1:0];
    assign misaligned_o = mis_q;
`else
    logic unused_tgt;

    assign target     = {branch_target_i[31:2], 2'b00};
    assign unused_tgt = ^branch_target_i[1:0];
`endif

    assign transfer = valid_q & output_ready_i;
    assign room     = ~valid_q | transfer;

    assign wb_cyc_o = (state_q == REQUEST) || (state_q == WAIT_ACK);
    assign wb_stb_o = (state_q == REQUEST);
    assign wb_adr_o = pc_q;
    assign wb_we_o  = 1'b0;
    assign wb_sel_o = 4'hF;

    assign output_valid_o = valid_q;
    assign instr_o        = instr_q;
    assign pc_o           = bpc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q & ~transfer;
        instr_d = instr_q;
        bpc_d   = bpc_q;
        drop_d  = drop_q;
        mis_d   = mis_q;

        unique case (state_q)
            START: state_d = REQUEST;
            REQUEST: begin
                if (!wb_stall_i)
                    state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (wb_ack_i) begin
                    drop_d  = 1'b0;
                    state_d = REQUEST;
                    // A full, unconsumed buffer keeps its word; the
                    // acked word is discarded and refetched from pc later.
                    if (!drop_q) begin
                        if (room) begin
                            valid_d = 1'b1;
                            instr_d = wb_dat_i;
                            bpc_d   = pc_q;
                            mis_d   = 1'b0;
                            pc_d    = pc_q + 32'd4;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (transfer && !mis_q)
                    state_d = REQUEST;
            end
            default: state_d = START;
        endcase

        if (branch_i) begin
            pc_d    = target;
            valid_d = 1'b0;
            mis_d   = 1'b0;
            unique case (state_q)
                START, HOLD: state_d = REQUEST;
                REQUEST: begin
                    state_d = wb_stall_i ? REQUEST : WAIT_ACK;
                    drop_d  = ~wb_stall_i;
                end
                WAIT_ACK: begin
                    state_d = wb_ack_i ? REQUEST : WAIT_ACK;
                    drop_d  = ~wb_ack_i;
                end
                default: state_d = START;
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            // Misaligned target: park with a NOP marker, no bus traffic.
            if (target_mis) begin
                state_d = HOLD;
                drop_d  = 1'b0;
                valid_d = 1'b1;
                instr_d = NOP;
                bpc_d   = target;
                mis_d   = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= START;
            pc_q    <= BOOT_ADDRESS;
            instr_q <= 32'h0;
            bpc_q   <= 32'h0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            bpc_q   <= bpc_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios then random stall/ready/redirect traffic
// checked against a delivered-stream model (sequential PCs, restarting at each redirect).
module tb_fetch_unit;

    localparam logic [31:0] BOOT = 32'h00000100;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        output_valid_o;
    logic        output_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        misaligned_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_stall_i;

    always #5 clk = ~clk;

    fetch_unit #(.BOOT_ADDRESS(BOOT)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .branch_i(branch_i),
        .branch_target_i(branch_target_i),
        .output_valid_o(output_valid_o),
        .output_ready_i(output_ready_i),
        .instr_o(instr_o),
        .pc_o(pc_o),
`ifdef FETCH_MISALIGN_CHECK_EN
        .misaligned_o(misaligned_o),
`endif
        .wb_adr_o(wb_adr_o),
        .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i),
        .wb_stall_i(wb_stall_i)
    );

`ifndef FETCH_MISALIGN_CHECK_EN
    assign misaligned_o = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    int          lat;
    logic        ready_c, stall_c, branch_c;
    logic [31:0] target_c;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    logic [31:0] exp_pc;
    logic        hold_chk, br_chk, parked, mis_exp;
    logic [31:0] hold_instr, hold_pc, mis_pc;
    int          delivered = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a + 32'hA0;
    endfunction

    // One cycle: we sit at a negedge, decide inputs, book-keep, advance.
    task automatic tick();
        logic mis;
        if (hold_chk) begin
            check("hold_valid", 32'(output_valid_o), 32'd1);
            check("hold_instr", instr_o, hold_instr);
            check("hold_pc", pc_o, hold_pc);
        end
        if (br_chk) check("flush_valid", 32'(output_valid_o), 32'd0);
        if (parked) check("parked_stb", 32'(wb_stb_o), 32'd0);
        hold_chk = 1'b0;
        br_chk   = 1'b0;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        if (pend && !wb_cyc_o) pend = 1'b0;
        if (pend) begin
            if (cnt == 0) begin
                wb_ack_i = 1'b1;
                wb_dat_i = mem(paddr);
                pend     = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (wb_cyc_o && wb_stb_o && !stall_c) begin
            check("one_outstanding", 32'(pend), 32'd0);
            pend  = 1'b1;
            paddr = wb_adr_o;
            cnt   = (lat < 0) ? int'($urandom_range(2, 0)) : lat;
        end
        if (output_valid_o && ready_c) begin
            if (mis_exp) begin
                check("mis_instr", instr_o, 32'h00000013);
                check("mis_pc", pc_o, mis_pc);
                check("mis_flag", 32'(misaligned_o), 32'd1);
                mis_exp = 1'b0;
            end else begin
                check("deliver_pc", pc_o, exp_pc);
                check("deliver_instr", instr_o, mem(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            delivered++;
        end else if (output_valid_o && !branch_c) begin
            hold_chk   = 1'b1;
            hold_instr = instr_o;
            hold_pc    = pc_o;
        end
        if (branch_c) begin
            mis = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis = (target_c[1:0] != 2'b00);
`endif
            parked  = mis;
            mis_exp = mis;
            mis_pc  = target_c;
            if (!mis) begin
                exp_pc = {target_c[31:2], 2'b00};
                br_chk = 1'b1;
            end
        end
        output_ready_i  = ready_c;
        wb_stall_i      = stall_c;
        branch_i        = branch_c;
        branch_target_i = target_c;
        @(posedge clk);
        @(negedge clk);
        branch_c = 1'b0;
        branch_i = 1'b0;
        wb_ack_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        branch_i = 1'b0; branch_target_i = 32'h0;
        output_ready_i = 1'b0; wb_dat_i = 32'h0;
        wb_ack_i = 1'b0; wb_stall_i = 1'b0;
        ready_c = 1'b1; stall_c = 1'b0; branch_c = 1'b0; target_c = 32'h0;
        lat = 0; pend = 1'b0; cnt = 0; paddr = 32'h0; exp_pc = BOOT;
        hold_chk = 1'b0; br_chk = 1'b0; parked = 1'b0; mis_exp = 1'b0;
        hold_instr = 32'h0; hold_pc = 32'h0; mis_pc = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_valid", 32'(output_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_adr", wb_adr_o, BOOT);
        check("rst_we", 32'(wb_we_o), 32'd0);
        check("rst_sel", 32'(wb_sel_o), 32'hF);
        rst = 1'b0;

        // Boot and zero-wait latency
        tick();
        check("boot_stb", 32'(wb_stb_o), 32'd1);
        check("boot_adr", wb_adr_o, BOOT);
        tick();
        check("boot_wait_cyc", 32'(wb_cyc_o), 32'd1);
        check("boot_wait_stb", 32'(wb_stb_o), 32'd0);
        tick();
        check("first_valid", 32'(output_valid_o), 32'd1);
        check("first_instr", instr_o, 32'h000001A0);
        check("first_pc", pc_o, 32'h00000100);
        check("next_adr", wb_adr_o, 32'h00000104);

        // Slave stall in REQUEST
        stall_c = 1'b1;
        repeat (3) begin
            tick();
            check("stall_stb", 32'(wb_stb_o), 32'd1);
            check("stall_adr", wb_adr_o, 32'h00000104);
        end
        stall_c = 1'b0;
        tick();
        check("stall_accept_stb", 32'(wb_stb_o), 32'd0);
        tick();
        check("stall_pc", pc_o, 32'h00000104);
        check("stall_instr", instr_o, 32'h000001A4);

        // Decode backpressure with a full buffer
        ready_c = 1'b0;
        tick();
        tick();
        check("hold_cyc", 32'(wb_cyc_o), 32'd0);
        check("hold_keep", instr_o, 32'h000001A4);
        tick();
        check("hold_cyc2", 32'(wb_cyc_o), 32'd0);
        ready_c = 1'b1;
        tick();
        check("resume_stb", 32'(wb_stb_o), 32'd1);
        check("resume_adr", wb_adr_o, 32'h00000108);

        // Redirect while waiting for a slow ack
        lat = 2;
        tick();
        branch_c = 1'b1; target_c = 32'h00000200;
        tick();
        check("br_wait_cyc", 32'(wb_cyc_o), 32'd1);
        tick();
        check("br_wait_valid", 32'(output_valid_o), 32'd0);
        tick();
        check("br_drop_valid", 32'(output_valid_o), 32'd0);
        check("br_new_adr", wb_adr_o, 32'h00000200);
        check("br_new_stb", 32'(wb_stb_o), 32'd1);
        lat = 0;
        tick();
        tick();
        check("br_pc", pc_o, 32'h00000200);
        check("br_instr", instr_o, 32'h000002A0);

        // Redirect coinciding with ack
        tick();
        branch_c = 1'b1; target_c = 32'h00000300;
        tick();
        check("br_ack_valid", 32'(output_valid_o), 32'd0);
        check("br_ack_adr", wb_adr_o, 32'h00000300);
        tick();
        tick();
        check("br_ack_pc", pc_o, 32'h00000300);
        check("br_ack_instr", instr_o, 32'h000003A0);

`ifdef FETCH_MISALIGN_CHECK_EN
        branch_c = 1'b1; target_c = 32'h00000402;
        tick();
        check("mis_cyc", 32'(wb_cyc_o), 32'd0);
        check("mis_valid", 32'(output_valid_o), 32'd1);
        check("mis_out", 32'(misaligned_o), 32'd1);
        check("mis_nop", instr_o, 32'h00000013);
        check("mis_pco", pc_o, 32'h00000402);
        tick();
        check("mis_taken", 32'(output_valid_o), 32'd0);
        tick();
        check("mis_park", 32'(wb_stb_o), 32'd0);
        branch_c = 1'b1; target_c = 32'h00000500;
        tick();
        check("mis_clear", 32'(misaligned_o), 32'd0);
        check("mis_exit_adr", wb_adr_o, 32'h00000500);
`else
        stall_c = 1'b1;
        branch_c = 1'b1; target_c = 32'h00000402;
        tick();
        check("mask_adr", wb_adr_o, 32'h00000400);
        check("mask_valid", 32'(output_valid_o), 32'd0);
`endif

        // PC wrap at the top of the address space
        stall_c = 1'b1;
        branch_c = 1'b1; target_c = 32'hFFFFFFFC;
        tick();
        check("wrap_adr", wb_adr_o, 32'hFFFFFFFC);
        stall_c = 1'b0;
        tick();
        tick();
        check("wrap_pc", pc_o, 32'hFFFFFFFC);
        check("wrap_instr", instr_o, 32'h0000009C);
        check("wrap_next", wb_adr_o, 32'h00000000);

        // Reset mid-transaction with a stale ack right after release
        tick();
        rst = 1'b1;
        #1;
        check("mrst_cyc", 32'(wb_cyc_o), 32'd0);
        check("mrst_stb", 32'(wb_stb_o), 32'd0);
        check("mrst_valid", 32'(output_valid_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        wb_ack_i = 1'b0;
        check("stale_valid", 32'(output_valid_o), 32'd0);
        check("stale_adr", wb_adr_o, BOOT);
        pend = 1'b0; exp_pc = BOOT;
        hold_chk = 1'b0; br_chk = 1'b0; parked = 1'b0; mis_exp = 1'b0;
        tick();
        tick();
        check("reboot_pc", pc_o, BOOT);

        // Random traffic
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            ready_c  = ($urandom % 4) != 0;
            stall_c  = ($urandom % 3) == 0;
            branch_c = ($urandom % 16) == 0;
            if (($urandom % 8) == 0)
                target_c = 32'hFFFFFFF0 + ($urandom % 16);
            else
                target_c = $urandom & 32'h0000FFFF;
`ifdef FETCH_MISALIGN_CHECK_EN
            target_c[1:0] = 2'b00;
`endif
            tick();
        end
        check("progress", 32'(delivered > 200), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
